// File: rtl/algo_3r1w_traffic_gen.sv
// Traffic generator for the 3r1w algorithmic memory: initialises every address,
// drives concurrent 1W+3R traffic and checks each read response against the pattern.
module algo_3r1w_traffic_gen #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BITADDR  = 13,
    parameter int unsigned NUMADDR  = 8192,
    parameter int unsigned RD_DELAY = 2,
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned NUMOPS   = 1024,
    parameter int unsigned REFRESH  = 1,
    parameter int unsigned REFFREQ  = 6,
    parameter logic [31:0] SEED     = 32'hA5A5_5A5A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 refr,
    output logic                 write,
    output logic [BITADDR-1:0]   wr_adr,
    output logic [WIDTH-1:0]     din,
    output logic [2:0]           read,
    output logic [3*BITADDR-1:0] rd_adr,
    input  logic [3*WIDTH-1:0]   rd_dout,
    input  logic [2:0]           rd_vld,
    input  logic [2:0]           rd_serr,
    input  logic [2:0]           rd_derr,
    output logic [15:0]          err_cnt,
    output logic                 err_flag,
    output logic [1:0]           err_port,
    output logic [BITADDR-1:0]   err_adr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITRDY, S_INIT, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t                                r_state;
    logic                                  r_busy, r_done, r_refr, r_write;
    logic [BITADDR-1:0]                    r_wr_adr;
    logic [WIDTH-1:0]                      r_din;
    logic [2:0]                            r_read;
    logic [2:0][BITADDR-1:0]               r_rd_adr;
    logic [15:0]                           r_err_cnt;
    logic                                  r_err_flag;
    logic [1:0]                            r_err_port;
    logic [BITADDR-1:0]                    r_err_adr;
    logic [BITADDR-1:0]                    r_adr;
    logic [31:0]                           r_k;
    logic [31:0]                           r_refcnt;
    logic [31:0]                           r_blank;
    logic [RD_DELAY-1:0][2:0]              r_pv;
    logic [RD_DELAY-1:0][2:0][BITADDR-1:0] r_pa;

    logic [2:0]                            w_err;
    logic [1:0]                            w_nerr;
    logic [16:0]                           w_sum;
    logic [15:0]                           w_cnt_next;
    logic [1:0]                            w_first;
    logic [BITADDR-1:0]                    w_first_adr;
    logic                                  w_chk;

    function automatic logic [WIDTH-1:0] pat(input logic [BITADDR-1:0] a);
        return WIDTH'(a) ^ WIDTH'(SEED);
    endfunction

    // base is always < NUMADDR, so one conditional subtract wraps the sum
    function automatic logic [BITADDR-1:0] wrap_add(input logic [BITADDR-1:0] b,
                                                    input int unsigned off);
        logic [BITADDR:0] s;
        s = {1'b0, b} + (BITADDR+1)'(off % NUMADDR);
        if (s >= (BITADDR+1)'(NUMADDR))
            s = s - (BITADDR+1)'(NUMADDR);
        return s[BITADDR-1:0];
    endfunction

    assign w_chk = (r_blank == '0);

    always_comb begin
        w_err = '0;
        for (int unsigned p = 0; p < 3; p++) begin
            if (r_pv[RD_DELAY-1][p] != rd_vld[p])
                w_err[p] = 1'b1;
            if (r_pv[RD_DELAY-1][p] && rd_vld[p] &&
                rd_dout[p*WIDTH +: WIDTH] != pat(r_pa[RD_DELAY-1][p]))
                w_err[p] = 1'b1;
            if (rd_vld[p] && (rd_serr[p] || rd_derr[p]))
                w_err[p] = 1'b1;
        end
        w_nerr     = 2'(w_err[0]) + 2'(w_err[1]) + 2'(w_err[2]);
        w_sum      = {1'b0, r_err_cnt} + 17'(w_nerr);
        w_cnt_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        if (w_err[0]) begin
            w_first     = 2'd0;
            w_first_adr = r_pa[RD_DELAY-1][0];
        end else if (w_err[1]) begin
            w_first     = 2'd1;
            w_first_adr = r_pa[RD_DELAY-1][1];
        end else begin
            w_first     = 2'd2;
            w_first_adr = r_pa[RD_DELAY-1][2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_refr     <= 1'b0;
            r_write    <= 1'b0;
            r_wr_adr   <= '0;
            r_din      <= '0;
            r_read     <= '0;
            r_rd_adr   <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
            r_err_port <= '0;
            r_err_adr  <= '0;
            r_adr      <= '0;
            r_k        <= '0;
            r_refcnt   <= '0;
            r_pv       <= '0;
            r_pa       <= '0;
            // responses to reads issued before reset are still in flight
            r_blank    <= RD_DELAY;
        end else begin
            r_write <= 1'b0;
            r_read  <= '0;
            r_refr  <= 1'b0;
            if (r_blank != '0)
                r_blank <= r_blank - 1;

            r_pv[0] <= r_read;
            r_pa[0] <= r_rd_adr;
            for (int unsigned d = 1; d < RD_DELAY; d++) begin
                r_pv[d] <= r_pv[d-1];
                r_pa[d] <= r_pa[d-1];
            end

            if (w_chk && w_nerr != 2'd0) begin
                r_err_cnt  <= w_cnt_next;
                r_err_flag <= 1'b1;
                if (!r_err_flag) begin
                    r_err_port <= w_first;
                    r_err_adr  <= w_first_adr;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAITRDY;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAITRDY: begin
                    if (ready) begin
                        r_state  <= S_INIT;
                        r_adr    <= '0;
                        r_k      <= '0;
                        r_refcnt <= '0;
                    end
                end
                S_INIT, S_RUN: begin
                    if (REFRESH != 0 && r_refcnt == REFFREQ - 1) begin
                        r_refcnt <= '0;
                        r_refr   <= 1'b1;
                    end else begin
                        r_refcnt <= r_refcnt + 1;
                        if (ready) begin
                            r_write <= 1'b1;
                            if (r_state == S_INIT) begin
                                r_wr_adr <= r_adr;
                                r_din    <= pat(r_adr);
                                if (r_adr == BITADDR'(NUMADDR - 1)) begin
                                    r_adr   <= '0;
                                    r_state <= S_RUN;
                                end else begin
                                    r_adr <= r_adr + 1'b1;
                                end
                            end else begin
                                r_read <= 3'b111;
                                for (int unsigned p = 0; p < 3; p++)
                                    r_rd_adr[p] <= wrap_add(r_adr, p * STRIDE);
                                r_wr_adr <= wrap_add(r_adr, 3 * STRIDE);
                                r_din    <= pat(wrap_add(r_adr, 3 * STRIDE));
                                r_adr    <= wrap_add(r_adr, 1);
                                if (r_k == NUMOPS - 1) begin
                                    r_k     <= '0;
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_k <= r_k + 1;
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_k == RD_DELAY - 1) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_k <= r_k + 1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state    <= S_WAITRDY;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err_cnt  <= '0;
                        r_err_flag <= 1'b0;
                        r_err_port <= '0;
                        r_err_adr  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign refr     = r_refr;
    assign write    = r_write;
    assign wr_adr   = r_wr_adr;
    assign din      = r_din;
    assign read     = r_read;
    assign rd_adr   = r_rd_adr;
    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;
    assign err_port = r_err_port;
    assign err_adr  = r_err_adr;

endmodule

// File: tb/tb_algo_3r1w_traffic_gen.sv
// Bench for algo_3r1w_traffic_gen: two instances (refresh off / refresh every 4 cycles)
// against an ideal latency-2 memory with fault injection on instance 0.
module tb_algo_3r1w_traffic_gen;

    localparam int unsigned W    = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned NA   = 16;
    localparam int unsigned NOPS = 8;
    localparam int unsigned RDD  = 2;
    localparam int unsigned RF   = 4;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
    logic s_rst = 1'b1, s_start = 1'b0, s_ready = 1'b0;
    int   cyc = 0;
    int   vecs = 0, miss = 0;
    logic cor_en = 1'b0, drop_en = 1'b0;

    logic [1:0]        busy, done, refr, write, err_flag;
    logic [AW-1:0]     wr_adr   [2];
    logic [W-1:0]      din      [2];
    logic [2:0]        read     [2];
    logic [3*AW-1:0]   rd_adr   [2];
    logic [3*W-1:0]    rd_dout  [2];
    logic [2:0]        rd_vld   [2];
    logic [2:0]        rd_serr  [2];
    logic [2:0]        rd_derr  [2];
    logic [15:0]       err_cnt  [2];
    logic [1:0]        err_port [2];
    logic [AW-1:0]     err_adr  [2];

    always #5 clk = ~clk;

    algo_3r1w_traffic_gen #(.WIDTH(W), .BITADDR(AW), .NUMADDR(NA), .RD_DELAY(RDD),
        .STRIDE(1), .NUMOPS(NOPS), .REFRESH(0), .REFFREQ(RF), .SEED(SEED)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .busy(busy[0]), .done(done[0]), .refr(refr[0]), .write(write[0]),
        .wr_adr(wr_adr[0]), .din(din[0]), .read(read[0]), .rd_adr(rd_adr[0]),
        .rd_dout(rd_dout[0]), .rd_vld(rd_vld[0]), .rd_serr(rd_serr[0]), .rd_derr(rd_derr[0]),
        .err_cnt(err_cnt[0]), .err_flag(err_flag[0]), .err_port(err_port[0]), .err_adr(err_adr[0]));

    algo_3r1w_traffic_gen #(.WIDTH(W), .BITADDR(AW), .NUMADDR(NA), .RD_DELAY(RDD),
        .STRIDE(1), .NUMOPS(NOPS), .REFRESH(1), .REFFREQ(RF), .SEED(SEED)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .busy(busy[1]), .done(done[1]), .refr(refr[1]), .write(write[1]),
        .wr_adr(wr_adr[1]), .din(din[1]), .read(read[1]), .rd_adr(rd_adr[1]),
        .rd_dout(rd_dout[1]), .rd_vld(rd_vld[1]), .rd_serr(rd_serr[1]), .rd_derr(rd_derr[1]),
        .err_cnt(err_cnt[1]), .err_flag(err_flag[1]), .err_port(err_port[1]), .err_adr(err_adr[1]));

    // ideal memory: array plus a RDD-deep response pipeline per instance
    logic [W-1:0]  mem [2][NA];
    logic [2:0]    mv  [2][RDD];
    logic [AW-1:0] ma  [2][RDD][3];
    logic [W-1:0]  md  [2][RDD][3];

    always @(posedge clk) begin
        s_rst   <= rst;
        s_start <= start;
        s_ready <= ready;
        cyc     <= cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (write[u]) mem[u][wr_adr[u]] <= din[u];
            mv[u][0] <= (cyc < 3) ? 3'b000 : read[u];
            for (int p = 0; p < 3; p++) begin
                ma[u][0][p] <= rd_adr[u][p*AW +: AW];
                md[u][0][p] <= mem[u][rd_adr[u][p*AW +: AW]];
            end
            for (int d = 1; d < RDD; d++) begin
                mv[u][d] <= (cyc < 3) ? 3'b000 : mv[u][d-1];
                for (int p = 0; p < 3; p++) begin
                    ma[u][d][p] <= ma[u][d-1][p];
                    md[u][d][p] <= md[u][d-1][p];
                end
            end
        end
    end

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            rd_vld[u]  = '0;
            rd_serr[u] = '0;
            rd_derr[u] = '0;
            rd_dout[u] = '0;
            for (int p = 0; p < 3; p++) begin
                rd_vld[u][p] = mv[u][RDD-1][p];
                rd_dout[u][p*W +: W] = md[u][RDD-1][p];
                if (u == 0 && cor_en && p == 1 && mv[u][RDD-1][p] && ma[u][RDD-1][p] == AW'(5))
                    rd_dout[u][p*W +: W] = md[u][RDD-1][p] ^ W'(1);
                if (u == 0 && drop_en && p != 1 && mv[u][RDD-1][0] && ma[u][RDD-1][0] == AW'(3))
                    rd_vld[u][p] = 1'b0;
            end
        end
    end

    // behavioural model: issue number n maps directly to the expected write/read addresses
    int            ph [2], n [2], c [2], dr [2];
    logic          e_busy [2], e_done [2], e_refr [2], e_write [2];
    logic [2:0]    e_read [2];
    logic [AW-1:0] e_wa [2];
    logic [W-1:0]  e_din [2];
    logic [AW-1:0] e_ra [2][3];

    int fw [2], dn [2];
    int nrefr0, nrefr1, nwr1, nrd1;

    function automatic logic [W-1:0] pat(input int a);
        return W'(a) ^ SEED;
    endfunction

    task automatic chk(input string nm, input int u, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, u, act, exp);
        end
    endtask

    task automatic model_step(input int u);
        int k, wa;
        e_write[u] = 1'b0;
        e_read[u]  = '0;
        e_refr[u]  = 1'b0;
        if (s_rst) begin
            ph[u] = 0; e_busy[u] = 1'b0; e_done[u] = 1'b0;
            e_wa[u] = '0; e_din[u] = '0;
            for (int p = 0; p < 3; p++) e_ra[u][p] = '0;
        end else begin
            case (ph[u])
                0: if (s_start) begin ph[u] = 1; e_busy[u] = 1'b1; end
                1: if (s_ready) begin ph[u] = 2; n[u] = 0; c[u] = 0; end
                2: begin
                    c[u]++;
                    if (u == 1 && c[u] % RF == 0) begin
                        e_refr[u] = 1'b1;
                    end else if (s_ready) begin
                        e_write[u] = 1'b1;
                        if (n[u] < NA) begin
                            e_wa[u]  = AW'(n[u]);
                            e_din[u] = pat(n[u]);
                        end else begin
                            k = (n[u] - NA) % NA;
                            e_read[u] = 3'b111;
                            for (int p = 0; p < 3; p++) e_ra[u][p] = AW'((k + p) % NA);
                            wa = (k + 3) % NA;
                            e_wa[u]  = AW'(wa);
                            e_din[u] = pat(wa);
                        end
                        n[u]++;
                        if (n[u] == NA + NOPS) begin ph[u] = 3; dr[u] = 0; end
                    end
                end
                3: begin
                    dr[u]++;
                    if (dr[u] == RDD) begin ph[u] = 4; e_busy[u] = 1'b0; e_done[u] = 1'b1; end
                end
                default: if (s_start) begin ph[u] = 1; e_busy[u] = 1'b1; e_done[u] = 1'b0; end
            endcase
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            model_step(u);
            if (s_rst) begin
                chk("rst_zero", u, {busy[u], done[u], refr[u], write[u], wr_adr[u], din[u], read[u],
                    rd_adr[u], err_cnt[u], err_flag[u], err_port[u], err_adr[u]}, '0);
            end else begin
                chk("ctl", u, {busy[u], done[u], refr[u], write[u], read[u]},
                    {e_busy[u], e_done[u], e_refr[u], e_write[u], e_read[u]});
                if (e_write[u]) begin
                    chk("wr_adr", u, wr_adr[u], e_wa[u]);
                    chk("din", u, din[u], e_din[u]);
                end
                for (int p = 0; p < 3; p++)
                    if (e_read[u][p]) chk("rd_adr", u, rd_adr[u][p*AW +: AW], e_ra[u][p]);
            end
            if (write[u] && fw[u] < 0) fw[u] = cyc;
            if (done[u] && dn[u] < 0) dn[u] = cyc;
        end
        nrefr0 += int'(refr[0]);
        nrefr1 += int'(refr[1]);
        nwr1   += int'(write[1]);
        if (read[1] == 3'b111) nrd1++;
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic clr_meas();
        fw[0] = -1; fw[1] = -1; dn[0] = -1; dn[1] = -1;
        nrefr0 = 0; nrefr1 = 0; nwr1 = 0; nrd1 = 0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (done !== 2'b11 && i < 300) begin
            step(1);
            i++;
        end
        chk("wait_done", 0, done, 2'b11);
        step(4);
    endtask

    task automatic chk_err(input int u, input int cnt, input int fl, input int port, input int adr);
        chk("err_cnt", u, err_cnt[u], cnt);
        chk("err_flag", u, err_flag[u], fl);
        chk("err_port", u, err_port[u], port);
        chk("err_adr", u, err_adr[u], adr);
    endtask

    initial begin
        clr_meas();
        step(3);
        rst = 1'b0;
        ready = 1'b1;
        step(2);

        // clean run; a start pulse during INIT must be ignored
        pulse_start();
        clr_meas();
        step(10);
        pulse_start();
        wait_done();
        chk("done_lat", 0, dn[0] - fw[0] + 1, 26);
        chk("done_lat", 1, dn[1] - fw[1] + 1, 33);
        chk("refr_cnt", 0, nrefr0, 0);
        chk("refr_cnt", 1, nrefr1, 7);
        chk("wr_cnt", 1, nwr1, 24);
        chk("rd_cnt", 1, nrd1, 8);
        chk_err(0, 0, 0, 0, 0);
        chk_err(1, 0, 0, 0, 0);

        // port 1 data corrupted once at address 5
        cor_en = 1'b1;
        pulse_start();
        wait_done();
        cor_en = 1'b0;
        chk_err(0, 1, 1, 1, 5);
        chk_err(1, 0, 0, 0, 0);

        // ports 0 and 2 lose rd_vld in the cycle port 0 returns address 3
        drop_en = 1'b1;
        pulse_start();
        wait_done();
        drop_en = 1'b0;
        chk_err(0, 2, 1, 0, 3);
        chk_err(1, 0, 0, 0, 0);

        // ready low for five cycles in the middle of RUN
        pulse_start();
        clr_meas();
        step(19);
        ready = 1'b0;
        step(5);
        ready = 1'b1;
        wait_done();
        chk("stall_lat", 0, dn[0] - fw[0] + 1, 31);
        chk_err(0, 0, 0, 0, 0);
        chk_err(1, 0, 0, 0, 0);

        // reset in the middle of RUN, then a fresh clean test
        pulse_start();
        step(20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        pulse_start();
        clr_meas();
        wait_done();
        chk("done_lat", 0, dn[0] - fw[0] + 1, 26);
        chk_err(0, 0, 0, 0, 0);
        chk_err(1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/algo_3r1w_traffic_gen.md
Name: algo_3r1w_traffic_gen

Overview:
- Self-checking stimulus master for the 3r1w algorithmic memory top (1 write port, 3 read ports).
- Drives write/read/refr into the memory and consumes rd_dout/rd_vld/rd_serr/rd_derr on the return path.
- Used in bring-up benches and on-chip BIST next to the memory and its assertion wrapper.
- Sequence: initialise every address with a known pattern, issue NUMOPS cycles of concurrent 1W+3R traffic, check every read response, report errors.

Parameters:
WIDTH, 32, data width per port
BITADDR, 13, address width
NUMADDR, 8192, number of addresses; all addresses wrap at NUMADDR
RD_DELAY, 2, read latency in cycles of the memory under test (>=1)
STRIDE, 1, address offset between successive ports
NUMOPS, 1024, number of RUN-phase issue cycles
REFRESH, 1, 1 = generate refr pulses
REFFREQ, 6, refresh period in cycles (>=2)
SEED, 32'hA5A5_5A5A, data scramble constant

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a test from IDLE
ready  in  1  memory ready; issue only while high
busy  out  1  high from start accept until DONE
done  out  1  high in DONE until next start or rst
refr  out  1  refresh request to memory
write  out  1  write enable
wr_adr  out  BITADDR  write address
din  out  WIDTH  write data
read  out  3  per-port read enable
rd_adr  out  3*BITADDR  read addresses, port p at [p*BITADDR +: BITADDR]
rd_dout  in  3*WIDTH  read data
rd_vld  in  3  read valid
rd_serr  in  3  single-bit error flag
rd_derr  in  3  double-bit error flag
err_cnt  out  16  saturating error count
err_flag  out  1  sticky; err_cnt != 0
err_port  out  2  port of first error
err_adr  out  BITADDR  address of first error

Behaviour:
- All outputs are registered. Reset value of every output is 0; reset also clears the FSM, counters, the expected pipeline and the first-error capture. Reset asserted mid-test aborts the test immediately: no further issue, outstanding responses are ignored.
- Pattern: pat(a) = a zero-extended to WIDTH, XOR SEED[WIDTH-1:0].
- FSM states and transitions:
  - IDLE -> WAITRDY on start. start is ignored in any other state except DONE.
  - WAITRDY -> INIT when ready=1.
  - INIT: write=1, wr_adr=i, din=pat(i), i = 0..NUMADDR-1; read=0. After i = NUMADDR-1 is issued, go to RUN.
  - RUN: for k = 0..NUMOPS-1, base = k mod NUMADDR.
    - read[p]=1 with rd_adr[p] = (base + p*STRIDE) mod NUMADDR.
    - write=1 with wr_adr = (base + 3*STRIDE) mod NUMADDR, din = pat(wr_adr).
    - After the last op, go to DRAIN.
  - DRAIN: no issue for RD_DELAY cycles, then DONE (busy=0, done=1).
  - DONE -> WAITRDY on start; err state is cleared on that start.
- Stall rules:
  - Whenever ready=0 in INIT or RUN, nothing is issued and the counters hold.
  - When REFRESH=1, a free-running counter active in INIT and RUN asserts refr for one cycle every REFFREQ cycles. In that cycle write=0, read=0 and the counters hold.
  - refr never coincides with write or read.
- Checking:
  - An expected pipeline of depth RD_DELAY carries {valid, addr} per port. A read issued at cycle t is checked at t+RD_DELAY.
  - One error is counted per port per cycle if any of the following holds:
    - expected and rd_vld=0 (missing)
    - not expected and rd_vld=1 (spurious)
    - expected, rd_vld=1 and rd_dout != pat(addr)
    - rd_vld=1 and (rd_serr or rd_derr)
  - Simultaneous errors on several ports in one cycle add the count of erroring ports.
  - First-error capture records the lowest-numbered erroring port in the earliest erroring cycle, then freezes.
  - err_cnt saturates at 16'hFFFF.
- Reads and the write to the same address in the same cycle are legal; the data is identical by construction.

Test Plan:
- NUMADDR=16, BITADDR=4, NUMOPS=8, RD_DELAY=2, REFRESH=0, ideal memory model:
  - start with ready=1 -> 16 INIT writes (addr 0..15), 8 RUN cycles, read ports at {k, k+1, k+2}, wr_adr=k+3.
  - done rises exactly 16+8+2 cycles after INIT entry; err_cnt=0.
- Same config, model corrupts port 1 data once at addr 5 -> err_cnt=1, err_port=1, err_adr=5, err_flag=1.
- Model drops rd_vld on ports 0 and 2 in one cycle -> err_cnt=2, err_port=0.
- REFRESH=1, REFFREQ=4 -> refr high every 4th cycle; read and write are 0 in those cycles; total issue count still 16 writes + 8 RUN cycles; err_cnt=0.
- ready=0 for 5 cycles mid-RUN -> no issue during the stall, counters resume at the held k; no spurious-vld errors.
- rst asserted mid-RUN -> next cycle all outputs 0, FSM in IDLE; a following start runs a clean test with err_cnt=0.
